// File: rtl/frame_anim_pkg.sv
// frame_anim_pkg: shared types and constants for the frame animator.
//   state_e       - animator FSM encoding (3 bits)
//   DEF_SCREEN_*  - default screen geometry in pixels
//   COLOUR_*      - 3-bit VGA colour constants
//   sat_inc8      - 8-bit saturating increment
package frame_anim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_MOVE  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_animator_pixel_offset_counter.sv
// pixel_offset_counter: raster-order offset walker over an S x S sprite.
//   clock, reset - system clock, asynchronous active-high reset
//   clear        - synchronous return to offset 0
//   step         - advance one pixel (wraps to 0 after the last pixel)
//   ox, oy       - column / row offset inside the sprite (ox varies fastest)
//   last         - high while the offset addresses the final pixel
module pixel_offset_counter #(
  parameter  int SPRITE_SIZE = 4,
  localparam int LW          = $clog2(SPRITE_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [LW-1:0] ox,
  output logic [LW-1:0] oy,
  output logic          last
);

  localparam logic [2*LW-1:0] ONE = 1;

  logic [2*LW-1:0] offset_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      offset_q <= '0;
    end else if (clear) begin
      offset_q <= '0;
    end else if (step) begin
      offset_q <= offset_q + ONE;
    end
  end

  assign ox   = offset_q[LW-1:0];
  assign oy   = offset_q[2*LW-1:LW];
  assign last = &offset_q;

endmodule

// File: rtl/frame_animator.sv
// frame_animator: on each frame tick (countdown reaching zero) erases a square
// sprite, steps its position with wall bounce, and redraws it through the VGA
// adapter's pixel-write port.
//   clock, reset    - system clock, asynchronous active-high reset
//   frame_counter   - countdown value from the frame-rate counter
//   enable          - when low, ticks are ignored (an update in flight finishes)
//   x, y, colour    - pixel write address and colour
//   plot            - pixel write strobe, one pixel per cycle, no backpressure:
//                     the adapter accepts every cycle in which plot is high
//   busy            - high whenever the FSM is not idle
//   frame_done      - one-cycle pulse when a frame update completes
//   dropped_frames  - saturating count of enabled ticks seen while busy
//   state_dbg       - current FSM state for debug/checkers
module frame_animator
  import frame_anim_pkg::*;
#(
  parameter int         SPRITE_SIZE   = 4,
  parameter int         SCREEN_W      = DEF_SCREEN_W,
  parameter int         SCREEN_H      = DEF_SCREEN_H,
  parameter logic [2:0] SPRITE_COLOUR = COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR     = COLOUR_BLACK
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] frame_counter,
  input  logic        enable,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  dropped_frames,
  output logic [2:0]  state_dbg
);

  localparam int         LW    = $clog2(SPRITE_SIZE);
  localparam logic [7:0] MAX_X = 8'(SCREEN_W - SPRITE_SIZE);
  localparam logic [6:0] MAX_Y = 7'(SCREEN_H - SPRITE_SIZE);

  state_e          state_q;
  logic            zero_q;
  logic [7:0]      pos_x_q, pos_x_d;
  logic [6:0]      pos_y_q, pos_y_d;
  logic            dir_x_neg_q, dir_x_neg_d;   // 0 = moving +1, 1 = moving -1
  logic            dir_y_neg_q, dir_y_neg_d;
  logic [7:0]      drop_q;

  logic            zero_now;
  logic            tick_en;
  logic            cnt_clear;
  logic            cnt_step;
  logic            cnt_last;
  logic [LW-1:0]   ox, oy;

  // Rising edge of "counter is zero": a counter parked at zero ticks once.
  assign zero_now = (frame_counter == 26'd0);
  assign tick_en  = zero_now & ~zero_q & enable;

  // The offset walker is shared by ERASE and DRAW; MOVE rewinds it between them.
  assign cnt_step  = (state_q == ST_ERASE) || (state_q == ST_DRAW);
  assign cnt_clear = (state_q == ST_IDLE)  || (state_q == ST_MOVE);

  pixel_offset_counter #(.SPRITE_SIZE(SPRITE_SIZE)) u_offset (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .step  (cnt_step),
    .ox    (ox),
    .oy    (oy),
    .last  (cnt_last)
  );

  // Bounce: at a wall the sprite reverses and steps one pixel back inward,
  // so it never rests on the wall for two consecutive frames.
  always_comb begin
    pos_x_d     = pos_x_q;
    dir_x_neg_d = dir_x_neg_q;
    pos_y_d     = pos_y_q;
    dir_y_neg_d = dir_y_neg_q;

    if (!dir_x_neg_q) begin
      if (pos_x_q == MAX_X) begin
        pos_x_d     = MAX_X - 8'd1;
        dir_x_neg_d = 1'b1;
      end else begin
        pos_x_d = pos_x_q + 8'd1;
      end
    end else begin
      if (pos_x_q == 8'd0) begin
        pos_x_d     = 8'd1;
        dir_x_neg_d = 1'b0;
      end else begin
        pos_x_d = pos_x_q - 8'd1;
      end
    end

    if (!dir_y_neg_q) begin
      if (pos_y_q == MAX_Y) begin
        pos_y_d     = MAX_Y - 7'd1;
        dir_y_neg_d = 1'b1;
      end else begin
        pos_y_d = pos_y_q + 7'd1;
      end
    end else begin
      if (pos_y_q == 7'd0) begin
        pos_y_d     = 7'd1;
        dir_y_neg_d = 1'b0;
      end else begin
        pos_y_d = pos_y_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      zero_q      <= 1'b1;
      pos_x_q     <= 8'd0;
      pos_y_q     <= 7'd0;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      zero_q <= zero_now;

      // Ticks during an update are counted, never queued.
      if (tick_en && (state_q != ST_IDLE)) begin
        drop_q <= sat_inc8(drop_q);
      end

      case (state_q)
        ST_IDLE:  if (tick_en)  state_q <= ST_ERASE;
        ST_ERASE: if (cnt_last) state_q <= ST_MOVE;
        ST_MOVE: begin
          pos_x_q     <= pos_x_d;
          pos_y_q     <= pos_y_d;
          dir_x_neg_q <= dir_x_neg_d;
          dir_y_neg_q <= dir_y_neg_d;
          state_q     <= ST_DRAW;
        end
        ST_DRAW:  if (cnt_last) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from registered state and offset only.
  assign plot   = cnt_step;
  assign x      = plot ? (pos_x_q + {{(8-LW){1'b0}}, ox}) : 8'd0;
  assign y      = plot ? (pos_y_q + {{(7-LW){1'b0}}, oy}) : 7'd0;
  assign colour = (state_q == ST_DRAW)  ? SPRITE_COLOUR :
                  (state_q == ST_ERASE) ? BG_COLOUR     : 3'b000;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);
  assign dropped_frames = drop_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_frame_animator.sv
module tb_frame_animator;

  localparam int S    = 4;
  localparam int S2   = S * S;
  localparam int MAXX = 160 - S;
  localparam int MAXY = 120 - S;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [25:0] frame_counter = 26'd10;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, frame_done;
  logic [7:0]  dropped_frames;
  logic [2:0]  state_dbg;

  int vectors    = 0;
  int miscompares = 0;

  always #10 clock = ~clock;

  frame_animator dut (
    .clock          (clock),
    .reset          (reset),
    .frame_counter  (frame_counter),
    .enable         (enable),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .plot           (plot),
    .busy           (busy),
    .frame_done     (frame_done),
    .dropped_frames (dropped_frames),
    .state_dbg      (state_dbg)
  );

  // ---------------- reference model ----------------
  // Timeline view: an accepted tick at edge E owns edges E..E+34; pixels are
  // the raster list of the old square then the new square.
  int  cyc     = 0;
  int  m_start = -1000;
  int  m_drops = 0;
  int  m_px = 0, m_py = 0, m_dx = 1, m_dy = 1;
  bit  m_prev_zero = 1'b1;
  logic [17:0] exp_q[$];
  int  frames_seen = 0;
  int  first_draw_x = -1;
  bit  in_draw = 1'b0;

  function automatic void step_axis(inout int p, inout int d, input int mx);
    if (d > 0) begin
      if (p == mx) begin p = mx - 1; d = -1; end
      else p = p + 1;
    end else begin
      if (p == 0) begin p = 1; d = 1; end
      else p = p - 1;
    end
  endfunction

  function automatic void push_sprite(input int px, input int py, input logic [2:0] c);
    for (int oy = 0; oy < S; oy++)
      for (int ox = 0; ox < S; ox++)
        exp_q.push_back({8'(px + ox), 7'(py + oy), c});
  endfunction

  function automatic void model_reset();
    m_start = -1000; m_drops = 0;
    m_px = 0; m_py = 0; m_dx = 1; m_dy = 1;
    m_prev_zero = 1'b1;
    exp_q.delete();
    in_draw = 1'b0;
  endfunction

  function automatic logic [25:0] rand_nz();
    return 26'($urandom_range(67108863, 1));
  endfunction

  always @(posedge clock) begin
    bit z;
    cyc = cyc + 1;
    z = (frame_counter == 26'd0);
    if (reset) begin
      m_prev_zero = 1'b1;
    end else begin
      if (z && !m_prev_zero && enable) begin
        if (cyc - m_start <= 2 * S2 + 2) begin
          if (m_drops < 255) m_drops = m_drops + 1;
        end else begin
          m_start = cyc;
          push_sprite(m_px, m_py, 3'b000);
          step_axis(m_px, m_dx, MAXX);
          step_axis(m_py, m_dy, MAXY);
          push_sprite(m_px, m_py, 3'b111);
        end
      end
      m_prev_zero = z;
    end
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  always @(negedge clock) begin
    int d;
    bit e_plot, e_busy, e_done;
    logic [17:0] e;
    if (!reset) begin
      d      = cyc - m_start;
      e_busy = (d >= 0) && (d <= 2 * S2 + 1);
      e_done = (d == 2 * S2 + 1);
      e_plot = ((d >= 0) && (d < S2)) || ((d >= S2 + 1) && (d <= 2 * S2));
      vectors++;
      if (plot !== e_plot) begin
        miscompares++;
        $display("FAIL plot cyc=%0d got=%b exp=%b", cyc, plot, e_plot);
      end
      vectors++;
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
      end
      vectors++;
      if (frame_done !== e_done) begin
        miscompares++;
        $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, e_done);
      end
      vectors++;
      if (dropped_frames !== 8'(m_drops)) begin
        miscompares++;
        $display("FAIL dropped cyc=%0d got=%0d exp=%0d", cyc, dropped_frames, m_drops);
      end
      if (plot === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pixel_unexpected cyc=%0d got=(%0d,%0d,%b) exp=none", cyc, x, y, colour);
        end else begin
          e = exp_q.pop_front();
          if ({x, y, colour} !== e) begin
            miscompares++;
            $display("FAIL pixel cyc=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)",
                     cyc, x, y, colour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end
      if (frame_done === 1'b1) frames_seen++;
      if (plot === 1'b1 && colour === 3'b111) begin
        if (!in_draw) first_draw_x = int'(x);
        in_draw = 1'b1;
      end else begin
        in_draw = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_once();
    @(negedge clock) frame_counter = rand_nz();
    @(negedge clock) frame_counter = 26'd0;
    @(negedge clock) frame_counter = rand_nz();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout got busy=%b exp=0", busy);
    end
    @(negedge clock);
  endtask

  // Zero sampled at edges base+k0 and base+k1, nonzero elsewhere.
  task automatic drive_rel(input int base, input int k0, input int k1, input int ncyc);
    int t;
    for (int i = 0; i < ncyc; i++) begin
      t = cyc + 1 - base;
      frame_counter = (t == k0 || t == k1) ? 26'd0 : rand_nz();
      @(negedge clock);
    end
    frame_counter = rand_nz();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++; if (x !== 8'd0)       begin miscompares++; $display("FAIL rst_x got=%0d exp=0", x); end
    vectors++; if (y !== 7'd0)       begin miscompares++; $display("FAIL rst_y got=%0d exp=0", y); end
    vectors++; if (colour !== 3'd0)  begin miscompares++; $display("FAIL rst_colour got=%b exp=000", colour); end
    vectors++; if (plot !== 1'b0)    begin miscompares++; $display("FAIL rst_plot got=%b exp=0", plot); end
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    vectors++; if (dropped_frames !== 8'd0) begin miscompares++; $display("FAIL rst_dropped got=%0d exp=0", dropped_frames); end
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_first_frame();
    int n;
    int f0;
    f0 = frames_seen;
    @(negedge clock) frame_counter = 26'd2;
    @(negedge clock) frame_counter = 26'd1;
    @(negedge clock) frame_counter = 26'd0;
    @(negedge clock) frame_counter = 26'd10;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    vectors++;
    if (n != 2 * S2 + 1) begin
      miscompares++;
      $display("FAIL done_latency got=%0d exp=%0d", n, 2 * S2 + 1);
    end
    wait_idle();
    vectors++;
    if (first_draw_x != 1) begin
      miscompares++;
      $display("FAIL first_draw_x got=%0d exp=1", first_draw_x);
    end
    vectors++;
    if (frames_seen - f0 != 1) begin
      miscompares++;
      $display("FAIL first_frames got=%0d exp=1", frames_seen - f0);
    end
  endtask

  task automatic test_right_wall();
    for (int it = 0; it < 400 && !(m_px == MAXX && m_dx == 1); it++) begin
      tick_once();
      wait_idle();
    end
    vectors++;
    if (!(m_px == MAXX && m_dx == 1)) begin
      miscompares++;
      $display("FAIL wall_preload got=%0d exp=%0d", m_px, MAXX);
    end
    tick_once();
    wait_idle();
    vectors++;
    if (first_draw_x != MAXX - 1) begin
      miscompares++;
      $display("FAIL wall_bounce_x got=%0d exp=%0d", first_draw_x, MAXX - 1);
    end
    tick_once();
    wait_idle();
    vectors++;
    if (first_draw_x != MAXX - 2) begin
      miscompares++;
      $display("FAIL wall_next_x got=%0d exp=%0d", first_draw_x, MAXX - 2);
    end
  endtask

  task automatic test_held_zero();
    int f0;
    f0 = frames_seen;
    @(negedge clock) frame_counter = 26'd0;
    repeat (100) @(negedge clock);
    frame_counter = rand_nz();
    wait_idle();
    vectors++;
    if (frames_seen - f0 != 1) begin
      miscompares++;
      $display("FAIL held_zero_frames got=%0d exp=1", frames_seen - f0);
    end
  endtask

  task automatic test_enable_low();
    int f0;
    int d0;
    f0 = frames_seen;
    d0 = m_drops;
    enable = 1'b0;
    tick_once();
    repeat (40) @(negedge clock);
    vectors++;
    if (frames_seen - f0 != 0) begin
      miscompares++;
      $display("FAIL disabled_frames got=%0d exp=0", frames_seen - f0);
    end
    // A frame in flight must complete when enable drops, and a disabled tick
    // during it is not a drop.
    enable = 1'b1;
    tick_once();
    repeat (3) @(negedge clock);
    enable = 1'b0;
    tick_once();
    wait_idle();
    enable = 1'b1;
    vectors++;
    if (frames_seen - f0 != 1) begin
      miscompares++;
      $display("FAIL enable_midframe_frames got=%0d exp=1", frames_seen - f0);
    end
    vectors++;
    if (dropped_frames !== 8'(d0)) begin
      miscompares++;
      $display("FAIL disabled_dropped got=%0d exp=%0d", dropped_frames, d0);
    end
  endtask

  task automatic test_drop_accounting();
    int f0;
    int d0;
    f0 = frames_seen;
    d0 = m_drops;
    tick_once();
    drive_rel(m_start, 5, 20, 40);
    wait_idle();
    vectors++;
    if (dropped_frames !== 8'(d0 + 2)) begin
      miscompares++;
      $display("FAIL drop_count got=%0d exp=%0d", dropped_frames, d0 + 2);
    end
    vectors++;
    if (frames_seen - f0 != 1) begin
      miscompares++;
      $display("FAIL drop_frames got=%0d exp=1", frames_seen - f0);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    int d0;
    f0 = frames_seen;
    d0 = m_drops;
    tick_once();
    drive_rel(m_start, 2 * S2 + 2, -99, 40);   // tick in DONE: dropped
    wait_idle();
    tick_once();
    drive_rel(m_start, 2 * S2 + 3, -99, 40);   // tick right after DONE: new frame
    wait_idle();
    vectors++;
    if (frames_seen - f0 != 3) begin
      miscompares++;
      $display("FAIL b2b_frames got=%0d exp=3", frames_seen - f0);
    end
    vectors++;
    if (dropped_frames !== 8'(d0 + 1)) begin
      miscompares++;
      $display("FAIL b2b_dropped got=%0d exp=%0d", dropped_frames, d0 + 1);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 700; i++) begin
      @(negedge clock);
      frame_counter = (i % 2 == 1) ? 26'd0 : rand_nz();
    end
    @(negedge clock) frame_counter = rand_nz();
    wait_idle();
    vectors++;
    if (dropped_frames !== 8'd255) begin
      miscompares++;
      $display("FAIL drop_saturate got=%0d exp=255", dropped_frames);
    end
  endtask

  task automatic test_reset_in_draw();
    int base;
    int n;
    tick_once();
    base = m_start;
    for (int i = 0; i < 100 && cyc != base + S2 + 1 + 7; i++) @(negedge clock);
    #2;
    vectors++;
    if (plot !== 1'b1 || colour !== 3'b111) begin
      miscompares++;
      $display("FAIL draw_px7 got plot=%b colour=%b exp plot=1 colour=111", plot, colour);
    end
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({plot, busy, frame_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset got=%b exp=000", {plot, busy, frame_done});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tick_once();
    n = 0;
    while (plot !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    vectors++;
    if ({x, y, colour} !== {8'd0, 7'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL post_reset_erase got=(%0d,%0d,%b) exp=(0,0,000)", x, y, colour);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_right_wall();
    test_held_zero();
    test_enable_low();
    test_drop_accounting();
    test_back_to_back();
    test_saturation();
    test_reset_in_draw();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pixels_left got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
